// File: rtl/bus_load_sequencer.sv
// Boot-time program loader: takes a length word then N data words and writes them
// into RAM over the shared bus (MAR load, then RAM write), holding the CPU off meanwhile.
module bus_load_sequencer #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_data,
  output logic              word_ready,
  output logic              bus_drive,
  output logic [DATA_W-1:0] bus_data,
  output logic              MAR_read,
  output logic              RAM_write,
  output logic              cpu_hold,
  output logic              PC_clear,
  output logic              load_busy,
  output logic              load_error,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_LEN   = 3'd1;
  localparam logic [2:0] S_WAIT_WORD = 3'd2;
  localparam logic [2:0] S_PUT_ADDR  = 3'd3;
  localparam logic [2:0] S_PUT_DATA  = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;
  localparam logic [2:0] S_ERR       = 3'd6;

  // Largest length that still ends at or below the top RAM address.
  localparam logic [63:0] MAX_LEN = (64'd1 << ADDR_W) - 64'(BASE_ADDR);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] data_reg;
  logic [ADDR_W:0]   words_written_q;
  logic              load_error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      addr            <= ADDR_W'(BASE_ADDR);
      remaining       <= '0;
      data_reg        <= '0;
      words_written_q <= '0;
      load_error_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERR: begin
          if (load_start) begin
            state           <= S_GET_LEN;
            addr            <= ADDR_W'(BASE_ADDR);
            words_written_q <= '0;
            load_error_q    <= 1'b0;
          end
        end
        S_GET_LEN: begin
          if (word_valid) begin
            if (word_data == '0) begin
              state <= S_FINISH;
            end else if (64'(word_data) > MAX_LEN) begin
              state        <= S_ERR;
              load_error_q <= 1'b1;
            end else begin
              remaining <= (ADDR_W+1)'(word_data);
              state     <= S_WAIT_WORD;
            end
          end
        end
        S_WAIT_WORD: begin
          if (word_valid) begin
            data_reg <= word_data;
            state    <= S_PUT_ADDR;
          end
        end
        S_PUT_ADDR: state <= S_PUT_DATA;
        S_PUT_DATA: begin
          addr            <= addr + ADDR_W'(1);
          remaining       <= remaining - (ADDR_W+1)'(1);
          words_written_q <= words_written_q + (ADDR_W+1)'(1);
          state           <= (remaining == (ADDR_W+1)'(1)) ? S_FINISH : S_WAIT_WORD;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Every output is a pure decode of registered state; no input reaches an output.
  always_comb begin
    word_ready = (state == S_GET_LEN) || (state == S_WAIT_WORD);
    bus_drive  = 1'b0;
    bus_data   = '0;
    MAR_read   = 1'b0;
    RAM_write  = 1'b0;
    case (state)
      S_PUT_ADDR: begin
        bus_drive = 1'b1;
        bus_data  = DATA_W'(addr);
        MAR_read  = 1'b1;
      end
      S_PUT_DATA: begin
        bus_drive = 1'b1;
        bus_data  = data_reg;
        RAM_write = 1'b1;
      end
      default: ;
    endcase
    cpu_hold      = (state != S_IDLE);
    PC_clear      = (state == S_FINISH);
    load_busy     = (state != S_IDLE) && (state != S_ERR);
    load_error    = load_error_q;
    words_written = words_written_q;
  end

endmodule

// File: tb/tb_bus_load_sequencer.sv
// Self-checking bench for bus_load_sequencer: a table of load scenarios plus hand-written
// sequences, with a RAM/MAR model and a write scoreboard fed at word acceptance.
module tb_bus_load_sequencer;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              load_start = 1'b0;
  logic              word_valid = 1'b0;
  logic [DATA_W-1:0] word_data = '0;
  logic              word_ready, bus_drive, MAR_read, RAM_write;
  logic              cpu_hold, PC_clear, load_busy, load_error;
  logic [DATA_W-1:0] bus_data;
  logic [ADDR_W:0]   words_written;

  bus_load_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .bus_drive(bus_drive), .bus_data(bus_data), .MAR_read(MAR_read),
    .RAM_write(RAM_write), .cpu_hold(cpu_hold), .PC_clear(PC_clear),
    .load_busy(load_busy), .load_error(load_error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                acc_cyc;
  } wr_t;

  typedef struct {
    int unsigned len;
    int unsigned gap;
    bit          fixed;
    bit          exp_err;
    int unsigned exp_ww;
  } rec_t;

  wr_t               exp_q[$];
  wr_t               exp_e;
  logic [DATA_W-1:0] ram_model [DEPTH];
  logic [ADDR_W-1:0] mar_model = '0;
  int                mar_cyc = 0;
  int                pc_count = 0;
  int                wr_count = 0;
  int                last_wr_addr = -1;
  logic [DATA_W-1:0] fixed_words [3];
  rec_t              tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus/RAM environment model and write scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!bus_drive) check("idle_bus_zero", 64'(bus_data), 64'd0);
      if (MAR_read) begin
        check("mar_exclusive", {62'd0, bus_drive, RAM_write}, 64'd2);
        check("mar_upper_zero", 64'(bus_data >> ADDR_W), 64'd0);
        mar_model = bus_data[ADDR_W-1:0];
        mar_cyc   = cyc;
      end
      if (RAM_write) begin
        check("wr_exclusive", {62'd0, bus_drive, MAR_read}, 64'd2);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got write at addr 0x%0h required none", mar_model);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_addr", 64'(mar_model), 64'(exp_e.addr));
          check("wr_data", 64'(bus_data), 64'(exp_e.data));
          check("wr_latency", 64'(cyc - exp_e.acc_cyc), 64'd2);
          check("mar_to_wr", 64'(cyc - mar_cyc), 64'd1);
        end
        ram_model[mar_model] = bus_data;
        wr_count++;
        last_wr_addr = int'(mar_model);
      end
      if (PC_clear) pc_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {56'd0, word_ready, bus_drive, MAR_read, RAM_write,
                            cpu_hold, PC_clear, load_busy, load_error}, 64'd0);
    check({name, "_bus"}, 64'(bus_data), 64'd0);
    check({name, "_ww"}, 64'(words_written), 64'd0);
  endtask

  // All driver tasks enter and leave just after a rising edge.
  task automatic do_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    pc_count = 0;
    @(negedge clk);
    check("start_hold", {60'd0, cpu_hold, load_busy, word_ready, load_error}, 64'hE);
    check("start_ww", 64'(words_written), 64'd0);
    tick();
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input bit is_data,
                           input int unsigned a, output int acc);
    bit ok = 0;
    acc = -1;
    word_valid = 1'b1;
    word_data  = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (word_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL word_accept_timeout: got no word_ready required accept of 0x%0h", d);
    end else begin
      acc = cyc;
      if (is_data) exp_q.push_back('{addr: ADDR_W'(a), data: d, acc_cyc: cyc});
    end
    tick();
    word_valid = 1'b0;
    word_data  = '0;
  endtask

  task automatic finish_check(input int unsigned exp_ww, output int waited);
    bit seen = 0;
    waited = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (PC_clear) begin
        seen = 1;
        break;
      end
      waited++;
      tick();
    end
    check("pc_clear_seen", 64'(seen), 64'd1);
    tick();
    @(negedge clk);
    check("done_released", {61'd0, cpu_hold, load_busy, PC_clear}, 64'd0);
    check("done_ww", 64'(words_written), 64'(exp_ww));
    check("done_pc_once", 64'(pc_count), 64'd1);
    check("done_queue_empty", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic run_load(input rec_t r);
    int acc, prev_acc, waited, wr_before;
    logic [DATA_W-1:0] d;
    wr_before = wr_count;
    prev_acc = 0;
    do_start();
    send_word(DATA_W'(r.len), 1'b0, 0, acc);
    if (r.exp_err) begin
      @(negedge clk);
      check("err_flags", {59'd0, load_error, cpu_hold, load_busy, bus_drive, word_ready}, 64'h18);
      check("err_ww", 64'(words_written), 64'(r.exp_ww));
      repeat (3) tick();
      check("err_no_writes", 64'(wr_count - wr_before), 64'd0);
      return;
    end
    for (int unsigned i = 0; i < r.len; i++) begin
      if (r.gap != 0) repeat (r.gap) tick();
      d = (r.fixed && i < 3) ? fixed_words[i] : DATA_W'($urandom);
      send_word(d, 1'b1, BASE_ADDR + i, acc);
      if (i > 0 && r.gap == 0) check("word_spacing", 64'(acc - prev_acc), 64'd3);
      prev_acc = acc;
    end
    finish_check(r.exp_ww, waited);
    check("load_writes", 64'(wr_count - wr_before), 64'(r.len));
    if (r.len == 0) check("zero_len_pc_next", 64'(waited), 64'd0);
    if (r.len == DEPTH - BASE_ADDR) check("last_addr", 64'(last_wr_addr), 64'(DEPTH - 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, waited;
    logic [DATA_W-1:0] w1, w2;

    fixed_words[0] = 32'hDEADBEEF;
    fixed_words[1] = 32'h00000001;
    fixed_words[2] = 32'hFFFFFFFF;
    tbl[0] = '{len: 3,    gap: 0, fixed: 1, exp_err: 0, exp_ww: 3};
    tbl[1] = '{len: 0,    gap: 0, fixed: 0, exp_err: 0, exp_ww: 0};
    tbl[2] = '{len: 2,    gap: 5, fixed: 0, exp_err: 0, exp_ww: 2};
    tbl[3] = '{len: 1025, gap: 0, fixed: 0, exp_err: 1, exp_ww: 0};
    tbl[4] = '{len: 1024, gap: 0, fixed: 0, exp_err: 0, exp_ww: 1024};
    tbl[5] = '{len: 1,    gap: 0, fixed: 0, exp_err: 0, exp_ww: 1};

    // Reset, with a word offered in IDLE that must not be taken.
    word_valid = 1'b1;
    word_data  = 32'h1234;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_zero("after_reset");
    end
    tick();
    word_valid = 1'b0;
    word_data  = '0;

    for (int i = 0; i < 6; i++) run_load(tbl[i]);

    // load_start during WAIT_WORD is ignored.
    do_start();
    send_word(DATA_W'(2), 1'b0, 0, acc);
    send_word(DATA_W'($urandom), 1'b1, BASE_ADDR, acc);
    repeat (2) tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    check("restart_ignored", {61'd0, word_ready, load_busy, load_error}, 64'h6);
    check("restart_ww", 64'(words_written), 64'd1);
    tick();
    send_word(DATA_W'($urandom), 1'b1, BASE_ADDR + 1, acc);
    finish_check(2, waited);

    // Reset asserted during PUT_DATA of the second word of a 4-word load.
    ram_model[BASE_ADDR + 1] = 32'hA5A5A5A5;
    w1 = 32'h13579BDF;
    w2 = 32'h2468ACE0;
    do_start();
    send_word(DATA_W'(4), 1'b0, 0, acc);
    send_word(w1, 1'b1, BASE_ADDR, acc);
    send_word(w2, 1'b1, BASE_ADDR + 1, acc);
    tick();
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    check("aborted_pending", 64'(exp_q.size()), 64'd1);
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_abort");
    check("abort_word1", 64'(ram_model[BASE_ADDR]), 64'(w1));
    check("abort_word2_absent", 64'(ram_model[BASE_ADDR + 1]), 64'hA5A5A5A5);
    repeat (3) tick();
    check("abort_no_late_write", 64'(ram_model[BASE_ADDR + 1]), 64'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
